// File: rtl/wrp_shff_pkg.sv
// rtl/wrp_shff_pkg.sv - shared constants and helpers for the shuffle wrapper blocks
package wrp_shff_pkg;

  localparam int OVF_CW        = 16;
  localparam int AXIS_TVALID_W = 1;
  localparam int AXIS_TREADY_W = 1;
  localparam int AXIS_TLAST_W  = 1;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/wrp_shff_fifo_ram.sv
// rtl/wrp_shff_fifo_ram.sv - DW x DEPTH dual-port RAM, synchronous write, asynchronous read
module wrp_shff_fifo_ram
  import wrp_shff_pkg::*;
#(
  parameter int DW    = 64,
  parameter int DEPTH = 64
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [clog2(DEPTH)-1:0] waddr,
  input  logic [DW-1:0]           wdata,
  input  logic [clog2(DEPTH)-1:0] raddr,
  output logic [DW-1:0]           rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/wrp_shff_fifo_axis_frm.sv
// rtl/wrp_shff_fifo_axis_frm.sv - write-side FIFO with registered AXIS master and TLAST framing
// Optional overflow statistics: WRP_SHFF_OVF_STAT_EN
module wrp_shff_fifo_axis_frm
  import wrp_shff_pkg::*;
#(
  parameter int DW        = 64,
  parameter int DEPTH     = 64,
  parameter int AF_MARGIN = 16,
  parameter int FRAME_LEN = 1024
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  fifo_we,
  input  logic [DW-1:0]         fifo_wd,
  output logic                  fifo_af,
  output logic [clog2(DEPTH):0] fifo_cnt,
  input  logic                  axi_rdy,
  output logic                  axi_vld,
  output logic [DW-1:0]         axi_dat,
  output logic                  axi_last,
  output logic                  ovf,
  output logic [OVF_CW-1:0]     ovf_cnt
);

  localparam int            AW     = clog2(DEPTH);
  localparam logic [AW:0]   FULL   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   AF_LVL = (AW+1)'(DEPTH - AF_MARGIN);

  logic          we_r;
  logic [DW-1:0] wd_r;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic [AW:0]   cnt_nxt;
  logic [DW-1:0] rd_data;
  logic          pop;
  logic          push_ok;

  // A full FIFO still accepts the registered push if a pop frees a slot this cycle.
  assign pop     = (cnt != '0) && (!axi_vld || axi_rdy);
  assign push_ok = we_r && ((cnt != FULL) || pop);

  always_comb begin
    cnt_nxt = cnt;
    case ({push_ok, pop})
      2'b10:   cnt_nxt = cnt + 1'b1;
      2'b01:   cnt_nxt = cnt - 1'b1;
      default: cnt_nxt = cnt;
    endcase
  end

  wrp_shff_fifo_ram #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (wd_r),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (srst) begin
      we_r     <= 1'b0;
      wd_r     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      fifo_cnt <= '0;
      fifo_af  <= 1'b0;
    end else begin
      we_r     <= fifo_we;
      wd_r     <= fifo_wd;
      cnt      <= cnt_nxt;
      fifo_cnt <= cnt_nxt;
      fifo_af  <= (cnt_nxt >= AF_LVL);
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      axi_vld <= 1'b0;
      axi_dat <= '0;
    end else if (pop) begin
      axi_vld <= 1'b1;
      axi_dat <= rd_data;
    end else if (axi_rdy) begin
      axi_vld <= 1'b0;
    end
  end

  generate
    if (FRAME_LEN > 0) begin : g_frm
      localparam int             FCW     = (FRAME_LEN > 1) ? clog2(FRAME_LEN) : 1;
      localparam logic [FCW-1:0] FRM_MAX = FCW'(FRAME_LEN - 1);

      logic [FCW-1:0] frm_cnt;
      logic           last_r;

      always_ff @(posedge clk) begin
        if (srst) begin
          frm_cnt <= '0;
          last_r  <= 1'b0;
        end else if (pop) begin
          last_r  <= (frm_cnt == FRM_MAX);
          frm_cnt <= (frm_cnt == FRM_MAX) ? '0 : frm_cnt + 1'b1;
        end
      end

      assign axi_last = last_r;
    end else begin : g_nofrm
      assign axi_last = 1'b0;
    end
  endgenerate

`ifdef WRP_SHFF_OVF_STAT_EN
  logic drop;
  assign drop = we_r && (cnt == FULL) && !pop;

  always_ff @(posedge clk) begin
    if (srst) begin
      ovf     <= 1'b0;
      ovf_cnt <= '0;
    end else if (drop) begin
      ovf <= 1'b1;
      if (ovf_cnt != {OVF_CW{1'b1}}) begin
        ovf_cnt <= ovf_cnt + 1'b1;
      end
    end
  end
`else
  assign ovf     = 1'b0;
  assign ovf_cnt = '0;
`endif

endmodule

// File: tb/tb_wrp_shff_fifo_axis_frm.sv
// tb/tb_wrp_shff_fifo_axis_frm.sv - self-checking bench with queue-based reference model
module tb_wrp_shff_fifo_axis_frm;

  localparam int DW        = 64;
  localparam int DEPTH     = 64;
  localparam int AF_MARGIN = 16;
  localparam int FRAME_LEN = 4;

  logic          clk = 1'b0;
  logic          srst;
  logic          fifo_we;
  logic [DW-1:0] fifo_wd;
  logic          fifo_af;
  logic [6:0]    fifo_cnt;
  logic          axi_rdy;
  logic          axi_vld;
  logic [DW-1:0] axi_dat;
  logic          axi_last;
  logic          ovf;
  logic [15:0]   ovf_cnt;

  always #5 clk = ~clk;

  wrp_shff_fifo_axis_frm #(
    .DW        (DW),
    .DEPTH     (DEPTH),
    .AF_MARGIN (AF_MARGIN),
    .FRAME_LEN (FRAME_LEN)
  ) dut (
    .clk      (clk),
    .srst     (srst),
    .fifo_we  (fifo_we),
    .fifo_wd  (fifo_wd),
    .fifo_af  (fifo_af),
    .fifo_cnt (fifo_cnt),
    .axi_rdy  (axi_rdy),
    .axi_vld  (axi_vld),
    .axi_dat  (axi_dat),
    .axi_last (axi_last),
    .ovf      (ovf),
    .ovf_cnt  (ovf_cnt)
  );

  int errors = 0;
  int checks = 0;

  // Reference: a word queue for storage, one output slot, one push pipeline slot.
  logic [DW-1:0] store[$];
  logic [DW-1:0] rx[$];
  logic          rxl[$];
  logic          m_vld, m_last, m_af, p_we;
  logic [DW-1:0] m_dat, p_wd;
  int            m_frm, m_drop;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic we, input logic [DW-1:0] wd, input logic rdy, input logic rst);
    bit pop;
    int sz;
    if (rst) begin
      store.delete();
      m_vld = 0; m_last = 0; m_af = 0; p_we = 0;
      m_dat = '0; p_wd = '0; m_frm = 0; m_drop = 0;
    end else begin
      sz  = store.size();
      pop = (sz > 0) && (!m_vld || rdy);
      if (pop) begin
        m_dat  = store.pop_front();
        m_vld  = 1;
        m_last = (m_frm == FRAME_LEN - 1);
        m_frm  = (m_frm + 1) % FRAME_LEN;
      end else if (m_vld && rdy) begin
        m_vld = 0;
      end
      if (p_we) begin
        if (sz < DEPTH || pop) store.push_back(p_wd);
        else m_drop++;
      end
      p_we = we;
      p_wd = wd;
      m_af = (store.size() >= DEPTH - AF_MARGIN);
    end
  endtask

  task automatic check_all();
    chk("cnt", fifo_cnt, store.size());
    chk("vld", axi_vld, m_vld);
    chk("af", fifo_af, m_af);
    if (m_vld) begin
      chk("dat", axi_dat, m_dat);
      chk("last", axi_last, m_last);
    end
`ifdef WRP_SHFF_OVF_STAT_EN
    chk("ovf", ovf, m_drop > 0);
    chk("ovf_cnt", ovf_cnt, (m_drop > 65535) ? 65535 : m_drop);
`else
    chk("ovf", ovf, 0);
    chk("ovf_cnt", ovf_cnt, 0);
`endif
  endtask

  task automatic step(input logic we, input logic [DW-1:0] wd, input logic rdy, input logic rst);
    fifo_we = we;
    fifo_wd = wd;
    axi_rdy = rdy;
    srst    = rst;
    if (!rst && axi_vld && rdy) begin
      rx.push_back(axi_dat);
      rxl.push_back(axi_last);
    end
    @(posedge clk);
    model_edge(we, wd, rdy, rst);
    #1;
    check_all();
  endtask

  initial begin
    int sent, n, bad;
    bit af_seen;
    srst = 1'b1; fifo_we = 1'b0; fifo_wd = '0; axi_rdy = 1'b0;

    // Reset and idle
    for (int i = 0; i < 3; i++) step(0, '0, 0, 1);
    chk("rst_vld", axi_vld, 0);
    chk("rst_cnt", fifo_cnt, 0);
    for (int i = 0; i < 5; i++) step(0, '0, 1, 0);
    chk("idle_vld", axi_vld, 0);

    // Latency: push at edge E, visible after E+2 for one cycle
    step(1, 64'hA5A5_0000_0000_0001, 1, 0);
    chk("lat_e0_vld", axi_vld, 0);
    step(0, '0, 1, 0);
    chk("lat_e1_vld", axi_vld, 0);
    step(0, '0, 1, 0);
    chk("lat_e2_vld", axi_vld, 1);
    chk("lat_e2_dat", axi_dat, 64'hA5A5_0000_0000_0001);
    step(0, '0, 1, 0);
    chk("lat_e3_vld", axi_vld, 0);

    // Backpressure with random ready
    rx.delete(); rxl.delete();
    sent = 0; n = 0;
    while (rx.size() < 100 && n < 3000) begin
      if (sent < 100 && !fifo_af && $urandom_range(0, 3) != 0) begin
        step(1, 64'(sent), 1'($urandom_range(0, 1)), 0);
        sent++;
      end else begin
        step(0, '0, 1'($urandom_range(0, 1)), 0);
      end
      n++;
    end
    chk("bp_count", rx.size(), 100);
    bad = 0;
    for (int i = 0; i < rx.size(); i++) if (rx[i] !== 64'(i)) bad++;
    chk("bp_order", bad, 0);

    // Almost-full and overflow with sink stalled
    step(0, '0, 0, 1);
    af_seen = 0;
    for (int i = 0; i < 81; i++) begin
      step(i < 80, 64'h4000 + 64'(i), 0, 0);
      if (!af_seen && fifo_af) begin
        af_seen = 1;
        chk("af_at_48", fifo_cnt, 48);
      end
    end
    chk("af_seen", af_seen, 1);
    chk("full_cnt", fifo_cnt, 64);
    chk("full_vld", axi_vld, 1);
    chk("full_dat", axi_dat, 64'h4000);
`ifdef WRP_SHFF_OVF_STAT_EN
    chk("full_ovf", ovf, 1);
    chk("full_ovf_cnt", ovf_cnt, 15);
`endif

    // Push and pop in the same cycle at full
    step(1, 64'hBEEF, 0, 0);
    step(0, '0, 1, 0);
    chk("fp_cnt", fifo_cnt, 64);
`ifdef WRP_SHFF_OVF_STAT_EN
    chk("fp_ovf_cnt", ovf_cnt, 15);
`endif
    rx.delete(); rxl.delete();
    for (int i = 0; i < 80; i++) step(0, '0, 1, 0);
    chk("fp_drain_n", rx.size(), 65);
    if (rx.size() == 65) begin
      chk("fp_first", rx[0], 64'h4001);
      chk("fp_last", rx[64], 64'hBEEF);
    end
    chk("fp_empty", fifo_cnt, 0);

    // Frames of 4 words
    step(0, '0, 0, 1);
    rx.delete(); rxl.delete();
    for (int i = 0; i < 12; i++) step(1, 64'h100 + 64'(i), 1, 0);
    for (int i = 0; i < 10; i++) step(0, '0, 1, 0);
    chk("frm_n", rx.size(), 12);
    bad = 0;
    for (int i = 0; i < rxl.size(); i++) if (rxl[i] !== ((i % 4) == 3)) bad++;
    chk("frm_last", bad, 0);

    // Reset mid-frame with words still in flight
    rx.delete(); rxl.delete();
    for (int i = 0; i < 8; i++) begin
      step(1, 64'h200 + 64'(i), 1, 0);
      if (rx.size() >= 6) break;
    end
    n = 0;
    while (rx.size() < 6 && n < 50) begin step(0, '0, 1, 0); n++; end
    chk("mid_n", rx.size(), 6);
    step(0, '0, 0, 1);
    chk("mid_rst_vld", axi_vld, 0);
    rx.delete(); rxl.delete();
    for (int i = 0; i < 4; i++) step(1, 64'h300 + 64'(i), 1, 0);
    for (int i = 0; i < 8; i++) step(0, '0, 1, 0);
    chk("post_n", rx.size(), 4);
    bad = 0;
    for (int i = 0; i < rxl.size(); i++) if (rxl[i] !== (i == 3)) bad++;
    chk("post_last", bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
